// File: rtl/led_status_pkg.sv
// led_status_pkg
//   Shared types and helpers for the LED status engine.
//   link_code_t : per-channel link code carried on link_st.
//   act_state_t : activity stretcher state.
//   ms_to_cycles: converts milliseconds to sys_clk cycles.
package led_status_pkg;

    typedef enum logic [1:0] {
        LINK_NONE = 2'b00,
        LINK_100M = 2'b01,
        LINK_1G   = 2'b10,
        LINK_10M  = 2'b11
    } link_code_t;

    typedef enum logic [1:0] {
        ACT_IDLE  = 2'd0,
        ACT_BLINK = 2'd1,
        ACT_HOLD  = 2'd2
    } act_state_t;

    // CLK_FREQ_HZ must be a multiple of 1000 so one ms is a whole number of cycles.
    function automatic int ms_to_cycles(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/led_act_stretch.sv
// led_act_stretch
//   Activity stretcher for one LED view. A single-cycle activity strobe
//   becomes a STRETCH_MS blink, followed by a STRETCH_MS hold-off. A strobe
//   seen during hold-off is remembered and replays a blink when hold ends.
// Ports:
//   sys_clk, sys_reset : clock, synchronous active-high reset
//   tick_ms            : one-cycle 1 ms timebase strobe
//   enable             : view has link; low forces IDLE and drops pending
//   act_pulse          : activity strobe
//   blink              : registered, high while the LED should be inverted
module led_act_stretch
    import led_status_pkg::*;
#(
    parameter int STRETCH_MS = 50
) (
    input  logic sys_clk,
    input  logic sys_reset,
    input  logic tick_ms,
    input  logic enable,
    input  logic act_pulse,
    output logic blink
);

    localparam int              CW   = $clog2(STRETCH_MS + 1);
    localparam logic [CW-1:0]   LAST = CW'(STRETCH_MS - 1);

    act_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          blink_q, blink_d;

    // Tick counting only starts with the first tick after entering a state,
    // so a blink is STRETCH_MS ms minus up to one ms.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        if (!enable) begin
            state_d = ACT_IDLE;
            cnt_d   = '0;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                ACT_IDLE: begin
                    if (act_pulse) begin
                        state_d = ACT_BLINK;
                        cnt_d   = '0;
                    end
                end
                ACT_BLINK: begin
                    // strobes here are intentionally ignored
                    if (tick_ms) begin
                        if (cnt_q == LAST) begin
                            state_d = ACT_HOLD;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ACT_HOLD: begin
                    if (act_pulse) pend_d = 1'b1;
                    if (tick_ms) begin
                        if (cnt_q == LAST) begin
                            cnt_d   = '0;
                            pend_d  = 1'b0;
                            state_d = (pend_q || act_pulse) ? ACT_BLINK : ACT_IDLE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ACT_IDLE;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end
            endcase
        end
        blink_d = (state_d == ACT_BLINK);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            state_q <= ACT_IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            blink_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            blink_q <= blink_d;
        end
    end

    assign blink = blink_q;

endmodule

// File: rtl/led_status_ctrl.sv
// led_status_ctrl
//   Parametrised LED status engine. Builds a shared timebase (1 ms tick,
//   fast/slow flash phases, breathing PWM), renders each channel's link code
//   and activity into a view, maps views onto registered LED pins.
// Ports:
//   sys_clk    : block clock
//   sys_reset  : synchronous active-high reset
//   link_st    : 2 bits per channel: 00 none, 01 100M, 10 1G, 11 10M
//   act_pulse  : per-channel single-cycle activity strobe
//   leds_out   : registered LED pins (ACTIVE_LOW selects polarity)
// Build option:
//   LED_STATUS_HEARTBEAT_EN - LED 0 becomes a breathing heartbeat and
//   views move up by one LED. Undefined: LED 0 is view 0.
module led_status_ctrl
    import led_status_pkg::*;
#(
    parameter int CLK_FREQ_HZ    = 100_000_000,
    parameter int CHANNEL_COUNT  = 4,
    parameter int LED_COUNT      = 8,
    parameter int COMBINE_PAIRS  = 0,
    parameter int ACTIVE_LOW     = 1,
    parameter int FAST_HALF_MS   = 168,
    parameter int SLOW_HALF_MS   = 336,
    parameter int BREATH_LEVELS  = 32,
    parameter int BREATH_STEP_MS = 16,
    parameter int ACT_STRETCH_MS = 50
) (
    input  logic                       sys_clk,
    input  logic                       sys_reset,
    input  logic [2*CHANNEL_COUNT-1:0] link_st,
    input  logic [CHANNEL_COUNT-1:0]   act_pulse,
    output logic [LED_COUNT-1:0]       leds_out
);

    localparam int   CYC_MS = ms_to_cycles(CLK_FREQ_HZ, 1);
    localparam int   PW     = $clog2(CYC_MS + 1);
    localparam int   FW     = $clog2(FAST_HALF_MS + 1);
    localparam int   SW     = $clog2(SLOW_HALF_MS + 1);
    localparam int   BW     = $clog2(BREATH_LEVELS + 1);
    localparam int   STW    = $clog2(BREATH_STEP_MS + 1);
    localparam int   VIEWS  = (COMBINE_PAIRS != 0) ? CHANNEL_COUNT / 2 : CHANNEL_COUNT;
    localparam logic POL    = (ACTIVE_LOW != 0);

    // ---------------- timebase ----------------
    logic [PW-1:0]  presc_q, presc_d;
    logic [FW-1:0]  fast_cnt_q, fast_cnt_d;
    logic [SW-1:0]  slow_cnt_q, slow_cnt_d;
    logic           fast_ph_q, fast_ph_d;
    logic           slow_ph_q, slow_ph_d;
    logic [BW-1:0]  pwm_q, pwm_d;
    logic [BW-1:0]  duty_q, duty_d;
    logic           duty_up_q, duty_up_d;
    logic [STW-1:0] step_q, step_d;
    logic           tick_ms;
    logic           breath_ph;

    assign tick_ms   = (presc_q == PW'(CYC_MS - 1));
    assign breath_ph = (pwm_q < duty_q);

    always_comb begin
        presc_d    = tick_ms ? '0 : presc_q + 1'b1;
        fast_cnt_d = fast_cnt_q;
        fast_ph_d  = fast_ph_q;
        slow_cnt_d = slow_cnt_q;
        slow_ph_d  = slow_ph_q;
        pwm_d      = (pwm_q == BW'(BREATH_LEVELS - 1)) ? '0 : pwm_q + 1'b1;
        duty_d     = duty_q;
        duty_up_d  = duty_up_q;
        step_d     = step_q;
        if (tick_ms) begin
            if (fast_cnt_q == FW'(FAST_HALF_MS - 1)) begin
                fast_cnt_d = '0;
                fast_ph_d  = ~fast_ph_q;
            end else begin
                fast_cnt_d = fast_cnt_q + 1'b1;
            end
            if (slow_cnt_q == SW'(SLOW_HALF_MS - 1)) begin
                slow_cnt_d = '0;
                slow_ph_d  = ~slow_ph_q;
            end else begin
                slow_cnt_d = slow_cnt_q + 1'b1;
            end
            // Triangle duty: turn around at the endpoint rather than
            // repeating it, so each endpoint is shown for one step only.
            if (step_q == STW'(BREATH_STEP_MS - 1)) begin
                step_d = '0;
                if (duty_up_q) begin
                    if (duty_q == BW'(BREATH_LEVELS - 1)) begin
                        duty_up_d = 1'b0;
                        duty_d    = duty_q - 1'b1;
                    end else begin
                        duty_d = duty_q + 1'b1;
                    end
                end else begin
                    if (duty_q == '0) begin
                        duty_up_d = 1'b1;
                        duty_d    = duty_q + 1'b1;
                    end else begin
                        duty_d = duty_q - 1'b1;
                    end
                end
            end else begin
                step_d = step_q + 1'b1;
            end
        end
    end

    // ---------------- views ----------------
    logic [VIEWS-1:0] view_base, view_up, view_act, view_blink, view_lit;

    for (genvar v = 0; v < VIEWS; v++) begin : g_view
        if (COMBINE_PAIRS != 0) begin : g_pair
            logic up_e, up_o;
            assign up_e = (link_code_t'(link_st[4*v +: 2])   != LINK_NONE);
            assign up_o = (link_code_t'(link_st[4*v+2 +: 2]) != LINK_NONE);
            // both: lit, even only: fast, odd only: slow, none: dark
            assign view_base[v] = (up_e & up_o) | (up_e & ~up_o & fast_ph_q) |
                                  (~up_e & up_o & slow_ph_q);
            assign view_up[v]   = up_e | up_o;
            assign view_act[v]  = act_pulse[2*v] | act_pulse[2*v+1];
        end else begin : g_single
            link_code_t lc;
            assign lc           = link_code_t'(link_st[2*v +: 2]);
            assign view_base[v] = (lc == LINK_1G) | ((lc == LINK_100M) & breath_ph) |
                                  ((lc == LINK_10M) & fast_ph_q);
            assign view_up[v]   = (lc != LINK_NONE);
            assign view_act[v]  = act_pulse[v];
        end

        led_act_stretch #(
            .STRETCH_MS (ACT_STRETCH_MS)
        ) u_act (
            .sys_clk   (sys_clk),
            .sys_reset (sys_reset),
            .tick_ms   (tick_ms),
            .enable    (view_up[v]),
            .act_pulse (view_act[v]),
            .blink     (view_blink[v])
        );

        assign view_lit[v] = view_base[v] ^ view_blink[v];
    end

    // ---------------- LED mapping ----------------
    logic [LED_COUNT-1:0] lit;

`ifdef LED_STATUS_HEARTBEAT_EN
    localparam int LED_OFS = 1;
    assign lit[0] = breath_ph;
`else
    localparam int LED_OFS = 0;
`endif

    // LEDs with no view stay dark; views past the last LED are dropped.
    for (genvar j = LED_OFS; j < LED_COUNT; j++) begin : g_led
        if (j - LED_OFS < VIEWS) begin : g_map
            assign lit[j] = view_lit[j-LED_OFS];
        end else begin : g_dark
            assign lit[j] = 1'b0;
        end
    end

    logic [LED_COUNT-1:0] leds_q, leds_d;
    assign leds_d = lit ^ {LED_COUNT{POL}};

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            presc_q    <= '0;
            fast_cnt_q <= '0;
            slow_cnt_q <= '0;
            fast_ph_q  <= 1'b0;
            slow_ph_q  <= 1'b0;
            pwm_q      <= '0;
            duty_q     <= '0;
            duty_up_q  <= 1'b1;
            step_q     <= '0;
            leds_q     <= {LED_COUNT{POL}};
        end else begin
            presc_q    <= presc_d;
            fast_cnt_q <= fast_cnt_d;
            slow_cnt_q <= slow_cnt_d;
            fast_ph_q  <= fast_ph_d;
            slow_ph_q  <= slow_ph_d;
            pwm_q      <= pwm_d;
            duty_q     <= duty_d;
            duty_up_q  <= duty_up_d;
            step_q     <= step_d;
            leds_q     <= leds_d;
        end
    end

    assign leds_out = leds_q;

endmodule

// File: tb/tb_led_status_ctrl.sv
// Bench for led_status_ctrl: one per-channel instance and one pair-combining
// instance, both on a 10 kHz clock (10 cycles per ms).
module tb_led_status_ctrl;

    logic       sys_clk   = 1'b0;
    logic       sys_reset = 1'b1;
    logic [7:0] link_a, link_c;
    logic [3:0] act_a, act_c;
    logic [7:0] leds_a, leds_c;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 sys_clk = ~sys_clk;

    led_status_ctrl #(
        .CLK_FREQ_HZ(10_000), .CHANNEL_COUNT(4), .LED_COUNT(8), .COMBINE_PAIRS(0),
        .ACTIVE_LOW(1), .FAST_HALF_MS(4), .SLOW_HALF_MS(8), .BREATH_LEVELS(8),
        .BREATH_STEP_MS(1), .ACT_STRETCH_MS(3)
    ) u_dut_a (
        .sys_clk(sys_clk), .sys_reset(sys_reset), .link_st(link_a),
        .act_pulse(act_a), .leds_out(leds_a)
    );

    led_status_ctrl #(
        .CLK_FREQ_HZ(10_000), .CHANNEL_COUNT(4), .LED_COUNT(8), .COMBINE_PAIRS(1),
        .ACTIVE_LOW(1), .FAST_HALF_MS(4), .SLOW_HALF_MS(8), .BREATH_LEVELS(8),
        .BREATH_STEP_MS(1), .ACT_STRETCH_MS(3)
    ) u_dut_c (
        .sys_clk(sys_clk), .sys_reset(sys_reset), .link_st(link_c),
        .act_pulse(act_c), .leds_out(leds_c)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int val, input int lo, input int hi);
        n_chk++;
        if (val < lo || val > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, val, lo, hi);
        end
    endtask

    // Leaves the bench 1 time unit after the edge that last sampled reset
    // high; the next posedge is the first one out of reset (edge 1).
    task automatic do_reset();
        sys_reset = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        sys_reset = 1'b0;
    endtask

    // Cycles that leds_a[idx] keeps level lvl (capped at bound); an activity
    // strobe on channel idx is injected at cycle pulse_at.
    task automatic measure(input int idx, input logic lvl, input int bound,
                           input int pulse_at, output int cnt);
        cnt = 0;
        while (leds_a[idx] === lvl && cnt < bound) begin
            act_a[idx] = (cnt == pulse_at);
            @(posedge sys_clk);
            #1;
            cnt++;
        end
        act_a[idx] = 1'b0;
    endtask

    // Expected duty after m breath steps: 0..7 then 6..1, period 14.
    function automatic int tri_duty(input int m);
        int r;
        r = m % 14;
        return (r <= 7) ? r : 14 - r;
    endfunction

    typedef struct {
        logic [7:0] link;
        logic [7:0] exp_a;
        logic [7:0] exp_c;
    } vec_t;

    initial begin
        vec_t vecs[5];
        int   c, k, bad_a, bad_c;
        logic e_fast, e_slow, e_breath;

        vecs[0] = '{8'h00, 8'hFF, 8'hFF};
        vecs[1] = '{8'h0A, 8'hFC, 8'hFE};   // ch0,ch1 1G; pair0 both up
        vecs[2] = '{8'hA0, 8'hF3, 8'hFD};   // ch2,ch3 1G; pair1 both up
        vecs[3] = '{8'hAA, 8'hF0, 8'hFC};
        vecs[4] = '{8'h88, 8'hF5, 8'hFF};   // not used on pairs: see below

        act_a  = '0;
        act_c  = '0;
        link_a = 8'hAA;
        link_c = 8'hAA;
        do_reset();

        // ---- static link patterns ----
        for (int i = 0; i < 4; i++) begin
            link_a = vecs[i].link;
            link_c = vecs[i].link;
            repeat (3) @(posedge sys_clk);
            #1;
            chk($sformatf("static_a[%0d]", i), 32'(leds_a), 32'(vecs[i].exp_a));
            chk($sformatf("static_c[%0d]", i), 32'(leds_c), 32'(vecs[i].exp_c));
        end
        link_a = vecs[4].link;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("static_a[4]", 32'(leds_a), 32'(vecs[4].exp_a));

        // ---- reset forces all dark the cycle after it is sampled ----
        link_a = 8'hAA;
        link_c = 8'hAA;
        repeat (3) @(posedge sys_clk);
        #1;
        sys_reset = 1'b1;
        @(posedge sys_clk);
        #1;
        chk("reset_a", 32'(leds_a), 32'hFF);
        chk("reset_c", 32'(leds_c), 32'hFF);

        // ---- timebase against closed-form model ----
        // After edge k out of reset: fast_ph = (k/40) odd, slow_ph = (k/80) odd,
        // breath = (k%8) < tri(k/10). The pin shows that one edge later.
        link_a = 8'h07;   // ch0 10M (fast), ch1 100M (breath)
        link_c = 8'h82;   // pair0 even only (fast), pair1 odd only (slow)
        do_reset();
        for (int n = 1; n <= 170; n++) begin
            @(posedge sys_clk);
            #1;
            k        = n - 1;
            e_fast   = ((k / 40) % 2) == 1;
            e_slow   = ((k / 80) % 2) == 1;
            e_breath = (k % 8) < tri_duty(k / 10);
            chk($sformatf("fast_a@%0d", n),   32'(leds_a[0]), 32'(!e_fast));
            chk($sformatf("breath_a@%0d", n), 32'(leds_a[1]), 32'(!e_breath));
            chk($sformatf("fast_c@%0d", n),   32'(leds_c[0]), 32'(!e_fast));
            chk($sformatf("slow_c@%0d", n),   32'(leds_c[1]), 32'(!e_slow));
            chk($sformatf("dark_c@%0d", n),   32'(leds_c[7:2]), 32'h3F);
        end

        // ---- no link: dark for 2000 cycles, activity ignored, mid reset ----
        link_a = 8'h00;
        link_c = 8'h00;
        do_reset();
        bad_a = 0;
        bad_c = 0;
        for (int n = 1; n <= 2000; n++) begin
            act_a     = (n % 100 == 50) ? 4'hF : 4'h0;
            act_c     = (n % 100 == 50) ? 4'hF : 4'h0;
            sys_reset = (n >= 500 && n < 502);
            @(posedge sys_clk);
            #1;
            if (leds_a !== 8'hFF) bad_a++;
            if (leds_c !== 8'hFF) bad_c++;
        end
        act_a     = '0;
        act_c     = '0;
        sys_reset = 1'b0;
        chk("idle_a_bad_cycles", 32'(bad_a), 32'd0);
        chk("idle_c_bad_cycles", 32'(bad_c), 32'd0);

        // ---- activity: blink, ignored pulse during blink, no re-blink ----
        link_a = 8'h02;   // ch0 1G, solid lit (pin low)
        link_c = 8'h0A;
        repeat (5) @(posedge sys_clk);
        #1;
        measure(0, 1'b0, 10, 0, c);
        chk_rng("blink1_rise", c, 1, 3);
        measure(0, 1'b1, 40, 5, c);
        chk_rng("blink1_len", c, 20, 31);
        measure(0, 1'b0, 45, -1, c);
        chk("blink1_no_reblink", 32'(c), 32'd45);

        // ---- activity: pulse in hold replays a blink when hold ends ----
        measure(0, 1'b0, 10, 0, c);
        chk_rng("blink2_rise", c, 1, 3);
        measure(0, 1'b1, 40, -1, c);
        chk_rng("blink2_len", c, 20, 31);
        measure(0, 1'b0, 40, 5, c);
        chk_rng("hold_len", c, 25, 31);
        measure(0, 1'b1, 40, -1, c);
        chk_rng("blink3_len", c, 20, 31);
        measure(0, 1'b0, 45, -1, c);
        chk("blink3_no_reblink", 32'(c), 32'd45);

        // ---- combined: odd-channel activity blinks the pair LED ----
        act_c[1] = 1'b1;
        @(posedge sys_clk);
        #1;
        act_c[1] = 1'b0;
        c = 0;
        while (leds_c[0] !== 1'b1 && c < 5) begin
            @(posedge sys_clk);
            #1;
            c++;
        end
        chk_rng("comb_odd_act_rise", c, 1, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
